hex_char_scroller: RTL and testbench

//  - Holds N_DIGITS 2-bit character codes and drives N_DIGITS active-low 7-seg displays.
//  - Rotates the characters one digit at a time on a divided-clock tick.
//  - Successor to the single-digit 2-bit character decoder, which is now a sub-module here.
//  - Top-level board block: SW/KEY feed it, HEX outputs go to the pins.

---
 rtl/hex_scroll_pkg.sv | 15 +
 rtl/char7seg.sv | 22 ++
 rtl/hex_char_scroller.sv | 90 +++++++++
 tb/tb_hex_char_scroller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hex_scroll_pkg.sv
// Shared constants for the hex character scroller: 2-bit character codes
// and their active-low 7-segment patterns (bit0 = segment a, 0 = lit).
package hex_scroll_pkg;

    localparam logic [1:0] CH_D     = 2'b00;
    localparam logic [1:0] CH_E     = 2'b01;
    localparam logic [1:0] CH_2     = 2'b10;
    localparam logic [1:0] CH_BLANK = 2'b11;

    localparam logic [6:0] SEG_D   = 7'b0100001;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/char7seg.sv
// Single-digit decoder: 2-bit character code to active-low 7-segment pattern.
// Purely combinational; one instance per display digit.
module char7seg
    import hex_scroll_pkg::*;
(
    input  logic [1:0] code,
    output logic [6:0] seg
);

    // Map each character code to its segment pattern; anything else stays dark.
    always_comb begin
        seg = SEG_OFF;
        case (code)
            CH_D:     seg = SEG_D;
            CH_E:     seg = SEG_E;
            CH_2:     seg = SEG_2;
            CH_BLANK: seg = SEG_OFF;
            default:  seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/hex_char_scroller.sv
// Board-level scroller: holds N_DIGITS 2-bit characters, rotates them one
// digit per divided-clock tick and drives N_DIGITS active-low 7-seg displays.
// Optional macro HEX_SCROLL_BIDIR_EN adds the dir port (0 = left, 1 = right);
// without it rotation is always left.
module hex_char_scroller
    import hex_scroll_pkg::*;
#(
    parameter int N_DIGITS = 6,
    parameter int TICK_DIV = 50_000_000
)
(
    input  logic                          CLOCK_50,
    input  logic                          RESET,
    input  logic [2*N_DIGITS-1:0]         pattern,
    input  logic                          load,
    input  logic                          run,
`ifdef HEX_SCROLL_BIDIR_EN
    input  logic                          dir,
`endif
    output logic [7*N_DIGITS-1:0]         HEX,
    output logic [$clog2(N_DIGITS)-1:0]   pos
);

    localparam int SW    = 2 * N_DIGITS;
    localparam int POS_W = $clog2(N_DIGITS);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_DIGITS - 1);

    logic [SW-1:0] slots;
    logic          tick;
    logic          rot_right;

`ifdef HEX_SCROLL_BIDIR_EN
    assign rot_right = dir;
`else
    assign rot_right = 1'b0;
`endif

    generate
        if (TICK_DIV == 1) begin : g_nodiv
            assign tick = run;
        end else begin : g_div
            localparam int CNT_W = $clog2(TICK_DIV);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

            logic [CNT_W-1:0] cnt;

            assign tick = run && (cnt == CNT_LAST);

            // Divider: counts only while running, holds otherwise, restarts on load/tick.
            always_ff @(posedge CLOCK_50) begin
                if (RESET || load) begin
                    cnt <= '0;
                end else if (tick) begin
                    cnt <= '0;
                end else if (run) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    // Character slots and rotation offset: reset blanks, load wins over a tick.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            slots <= '1;
            pos   <= '0;
        end else if (load) begin
            slots <= pattern;
            pos   <= '0;
        end else if (tick) begin
            if (rot_right) begin
                slots <= {slots[1:0], slots[SW-1:2]};
                pos   <= (pos == '0) ? POS_LAST : pos - POS_W'(1);
            end else begin
                slots <= {slots[SW-3:0], slots[SW-1:SW-2]};
                pos   <= (pos == POS_LAST) ? '0 : pos + POS_W'(1);
            end
        end
    end

    generate
        for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
            char7seg u_dec (
                .code (slots[2*i+1:2*i]),
                .seg  (HEX[7*i+6:7*i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_hex_char_scroller.sv
// Self-checking bench for hex_char_scroller (N_DIGITS=4, TICK_DIV=4).
// A rotation-offset model predicts HEX/pos every cycle; directed scenarios
// pin specific literal values. Honours HEX_SCROLL_BIDIR_EN if defined.
module tb_hex_char_scroller;

    localparam int N  = 4;
    localparam int TD = 4;

    localparam logic [6:0] L_D   = 7'b0100001;
    localparam logic [6:0] L_E   = 7'b0000110;
    localparam logic [6:0] L_2   = 7'b0100100;
    localparam logic [6:0] L_OFF = 7'b1111111;

    localparam logic [7:0] P1 = 8'b11_10_01_00;
    localparam logic [7:0] P2 = 8'b00_01_10_11;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic        run;
    logic        dir;
    logic [7:0]  pattern;
    logic [27:0] hex;
    logic [1:0]  pos;

    int nChecks = 0;
    int nFails  = 0;

    hex_char_scroller #(.N_DIGITS(N), .TICK_DIV(TD)) dut (
        .CLOCK_50 (clk),
        .RESET    (reset),
        .pattern  (pattern),
        .load     (load),
        .run      (run),
`ifdef HEX_SCROLL_BIDIR_EN
        .dir      (dir),
`endif
        .HEX      (hex),
        .pos      (pos)
    );

    // Free-running 100 MHz-style clock.
    always #5 clk = ~clk;

    // Model state: characters as last loaded, net left-rotation offset, run-cycle phase.
    logic [1:0] mLoaded [N];
    int         mOff   = 0;
    int         mPhase = 0;
    bit         mValid = 1'b0;

    function automatic logic [6:0] segOf(input logic [1:0] c);
        case (c)
            2'b00:   return L_D;
            2'b01:   return L_E;
            2'b10:   return L_2;
            default: return L_OFF;
        endcase
    endfunction

    function automatic logic [27:0] modelHex();
        logic [27:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[7*i +: 7] = segOf(mLoaded[(i - mOff + N) % N]);
        end
        return r;
    endfunction

    // Advance the model at every edge, then compare the DUT just after the edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) mLoaded[i] = 2'b11;
            mOff   = 0;
            mPhase = 0;
            mValid = 1'b1;
        end else if (load) begin
            for (int i = 0; i < N; i++) mLoaded[i] = pattern[2*i +: 2];
            mOff   = 0;
            mPhase = 0;
        end else if (run) begin
            if (mPhase == TD - 1) begin
                mPhase = 0;
`ifdef HEX_SCROLL_BIDIR_EN
                if (dir) mOff = (mOff + N - 1) % N;
                else     mOff = (mOff + 1) % N;
`else
                mOff = (mOff + 1) % N;
`endif
            end else begin
                mPhase = mPhase + 1;
            end
        end
        #1;
        if (mValid) begin
            nChecks++;
            if (hex !== modelHex()) begin
                nFails++;
                $display("[TB] FAIL model_hex t=%0t got=%h expected=%h", $time, hex, modelHex());
            end
            nChecks++;
            if (pos !== 2'(mOff)) begin
                nFails++;
                $display("[TB] FAIL model_pos t=%0t got=%0d expected=%0d", $time, pos, mOff);
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic ld, input logic rn, input logic [7:0] pat);
        reset   = r;
        load    = ld;
        run     = rn;
        pattern = pat;
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [27:0] expHex, input logic [1:0] expPos);
        nChecks++;
        if (hex !== expHex) begin
            nFails++;
            $display("[TB] FAIL %s hex got=%h expected=%h", name, hex, expHex);
        end
        nChecks++;
        if (pos !== expPos) begin
            nFails++;
            $display("[TB] FAIL %s pos got=%0d expected=%0d", name, pos, expPos);
        end
    endtask

    // Directed scenarios with hand-computed expectations.
    initial begin
        dir = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);

        cycle(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("reset", 28'hFFFFFFF, 2'd0);
        cycle(3);
        checkOutput("reset_hold", 28'hFFFFFFF, 2'd0);

        applyStimulus(1'b0, 1'b1, 1'b0, P1);
        cycle(1);
        checkOutput("load", 28'b1111111_0100100_0000110_0100001, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, P1);

        cycle(3);
        checkOutput("pre_first_tick", {L_OFF, L_2, L_E, L_D}, 2'd0);
        cycle(1);
        checkOutput("first_rotation", {L_2, L_E, L_D, L_OFF}, 2'd1);
        cycle(12);
        checkOutput("wrap", {L_OFF, L_2, L_E, L_D}, 2'd0);

        cycle(3);
        applyStimulus(1'b0, 1'b1, 1'b1, P2);
        cycle(1);
        checkOutput("load_over_tick", {L_D, L_E, L_2, L_OFF}, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, P2);
        cycle(3);
        checkOutput("after_load_no_rot", {L_D, L_E, L_2, L_OFF}, 2'd0);
        cycle(1);
        checkOutput("after_load_rot", {L_E, L_2, L_OFF, L_D}, 2'd1);

        cycle(2);
        applyStimulus(1'b0, 1'b0, 1'b0, P2);
        cycle(10);
        checkOutput("run_hold", {L_E, L_2, L_OFF, L_D}, 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, P2);
        cycle(1);
        checkOutput("resume_1", {L_E, L_2, L_OFF, L_D}, 2'd1);
        cycle(1);
        checkOutput("resume_2", {L_2, L_OFF, L_D, L_E}, 2'd2);

        cycle(4);
        checkOutput("pos3", {L_OFF, L_D, L_E, L_2}, 2'd3);
        applyStimulus(1'b1, 1'b0, 1'b1, P2);
        cycle(1);
        checkOutput("mid_reset", 28'hFFFFFFF, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, P2);
        cycle(2);
        checkOutput("post_reset_idle", 28'hFFFFFFF, 2'd0);

`ifdef HEX_SCROLL_BIDIR_EN
        applyStimulus(1'b0, 1'b1, 1'b0, P1);
        cycle(1);
        dir = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, P1);
        cycle(4);
        checkOutput("rotate_right", {L_D, L_OFF, L_2, L_E}, 2'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, P1);
        cycle(1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
